// File: rtl/prism_cnt_shift_unit.sv
// PRISM counter/shifter datapath: reloadable countdowns, compare up-counter,
// variable-length shifter and a capture FIFO popped over the register bus.
module prism_cnt_shift_unit #(
  parameter int NUM_CNT    = 2,
  parameter int CNT_W      = 24,
  parameter int UP_W       = 5,
  parameter int SHIFT_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_CNT-1:0] cnt_load,
  input  logic [NUM_CNT-1:0] cnt_dec,
  input  logic               up_inc,
  input  logic               up_clr,
  input  logic               shift,
  input  logic               ser_in,
  input  logic [5:0]         address,
  input  logic [31:0]        data_in,
  input  logic [1:0]         data_write_n,
  input  logic [1:0]         data_read_n,
  output logic [31:0]        data_out,
  output logic               data_ready,
  output logic [NUM_CNT-1:0] cnt_zero,
  output logic [NUM_CNT-1:0] cnt_wrap,
  output logic               cmp_match,
  output logic               shift_done,
  output logic               ser_out,
  output logic               irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [5:0] SW_M1 = 6'(SHIFT_W - 1);

  logic wr, rd;
  logic wr_ctrl, wr_stat, wr_cmp, wr_sh, rd_fifo;

  assign wr      = (data_write_n == 2'b10);
  assign rd      = (data_read_n != 2'b11);
  assign wr_ctrl = wr && (address == 6'h00);
  assign wr_stat = wr && (address == 6'h04);
  assign wr_cmp  = wr && (address == 6'h18);
  assign wr_sh   = wr && (address == 6'h1C);
  assign rd_fifo = rd && (address == 6'h20);

  logic               dir_q, dir_d;
  logic               fen_q, fen_d;
  logic               fie_q, fie_d;
  logic [3:0]         ar_q, ar_d;
  logic [4:0]         len_q, len_d;
  logic [CNT_W-1:0]   pre_q [NUM_CNT];
  logic [CNT_W-1:0]   pre_d [NUM_CNT];
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0] wrap_q, wrap_d;
  logic [UP_W-1:0]    up_q, up_d;
  logic [UP_W-1:0]    cmp_q, cmp_d;
  logic [SHIFT_W-1:0] sh_q, sh_d;
  logic [5:0]         bc_q, bc_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               evt_q, evt_d;
  logic [AW:0]        wp_q, wp_d;
  logic [AW:0]        rp_q, rp_d;
  logic [SHIFT_W-1:0] mem_q [FIFO_DEPTH];

  logic               unused_ok;
  assign unused_ok = &{1'b0, data_in};

  // Word length is clamped so an oversized len_m1 uses the full register.
  logic [5:0]         eff;
  logic [SHIFT_W:0]   sh_cat;
  logic [SHIFT_W-1:0] lmask, sh_l, sh_r, sh_rs, sh_nx;
  logic               msb, sh_fire, push_req, push, pop;
  logic [AW:0]        level;
  logic               empty, full;

  assign eff    = ({1'b0, len_q} > SW_M1) ? SW_M1 : {1'b0, len_q};
  assign sh_cat = {sh_q, ser_in};
  assign sh_l   = sh_cat[SHIFT_W-1:0];
  assign sh_rs  = sh_q >> 1;

  always_comb begin
    lmask = '0;
    sh_r  = sh_q;
    msb   = 1'b0;
    for (int i = 0; i < SHIFT_W; i++) begin
      lmask[i] = (6'(i) <= eff);
      if (6'(i) == eff) begin
        sh_r[i] = ser_in;
        msb     = sh_q[i];
      end else if (6'(i) < eff) begin
        sh_r[i] = sh_rs[i];
      end
    end
  end

  assign sh_nx    = dir_q ? sh_r : sh_l;
  assign ser_out  = dir_q ? sh_q[0] : msb;
  assign sh_fire  = enable && shift && !wr_sh;
  assign done_d   = sh_fire && (bc_q == eff);
  assign push_req = done_d && fen_q;

  assign level = wp_q - rp_q;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign pop   = rd_fifo && !empty;
  assign push  = push_req && (!full || pop);

  always_comb begin
    dir_d  = dir_q;
    fen_d  = fen_q;
    fie_d  = fie_q;
    ar_d   = ar_q;
    len_d  = len_q;
    wrap_d = '0;
    up_d   = up_q;
    cmp_d  = cmp_q;
    sh_d   = sh_q;
    bc_d   = bc_q;
    ovf_d  = ovf_q;
    evt_d  = evt_q;
    wp_d   = wp_q;
    rp_d   = rp_q;

    if (wr_ctrl) begin
      dir_d = data_in[0];
      fen_d = data_in[1];
      fie_d = data_in[2];
      ar_d  = data_in[7:4];
      len_d = data_in[12:8];
    end

    for (int k = 0; k < NUM_CNT; k++) begin
      pre_d[k] = pre_q[k];
      cnt_d[k] = cnt_q[k];
      if (wr && (address == 6'(8 + 4 * k)))
        pre_d[k] = data_in[CNT_W-1:0];
      if (enable && cnt_load[k] && !cnt_dec[k]) begin
        cnt_d[k] = pre_q[k];
      end else if (enable && cnt_dec[k] && !cnt_load[k]
                   && (cnt_q[k] != '0)) begin
        if (ar_q[k] && (cnt_q[k] == CNT_W'(1))) begin
          cnt_d[k]  = pre_q[k];
          wrap_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] - CNT_W'(1);
        end
      end
    end

    if (wr_cmp)
      cmp_d = data_in[UP_W-1:0];
    if (enable && up_inc && !up_clr)
      up_d = up_q + UP_W'(1);
    else if (enable && up_clr && !up_inc)
      up_d = '0;

    if (wr_sh) begin
      sh_d = data_in[SHIFT_W-1:0];
      bc_d = '0;
    end else if (sh_fire) begin
      sh_d = sh_nx;
      bc_d = done_d ? 6'd0 : bc_q + 6'd1;
    end

    if (push)
      wp_d = wp_q + (AW+1)'(1);
    if (pop)
      rp_d = rp_q + (AW+1)'(1);

    // A same-cycle hardware event beats the host's clear.
    if (wr_stat && data_in[2])
      ovf_d = 1'b0;
    if (push_req && full && !pop)
      ovf_d = 1'b1;
    if (wr_stat && data_in[3])
      evt_d = 1'b0;
    if (enable && up_inc && up_clr)
      evt_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q  <= 1'b0;
      fen_q  <= 1'b0;
      fie_q  <= 1'b0;
      ar_q   <= '0;
      len_q  <= '0;
      for (int k = 0; k < NUM_CNT; k++) begin
        pre_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      wrap_q <= '0;
      up_q   <= '0;
      cmp_q  <= '0;
      sh_q   <= '0;
      bc_q   <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      evt_q  <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      dir_q  <= dir_d;
      fen_q  <= fen_d;
      fie_q  <= fie_d;
      ar_q   <= ar_d;
      len_q  <= len_d;
      for (int k = 0; k < NUM_CNT; k++) begin
        pre_q[k] <= pre_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      wrap_q <= wrap_d;
      up_q   <= up_d;
      cmp_q  <= cmp_d;
      sh_q   <= sh_d;
      bc_q   <= bc_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      evt_q  <= evt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wp_q[AW-1:0]] <= sh_nx & lmask;
  end

  always_comb begin
    for (int k = 0; k < NUM_CNT; k++)
      cnt_zero[k] = (cnt_q[k] == '0);
  end

  assign cnt_wrap   = wrap_q;
  assign shift_done = done_q;
  assign cmp_match  = (up_q == cmp_q);
  assign data_ready = 1'b1;
  assign irq        = ovf_q | evt_q | (fie_q & !empty);

  always_comb begin
    data_out = '0;
    unique case (address)
      6'h00: data_out = {19'b0, len_q, ar_q, 1'b0, fie_q, fen_q, dir_q};
      6'h04: begin
        data_out[0]        = empty;
        data_out[1]        = full;
        data_out[2]        = ovf_q;
        data_out[3]        = evt_q;
        data_out[8 +: AW+1] = level;
      end
      6'h18: begin
        data_out[16 +: UP_W] = cmp_q;
        data_out[UP_W-1:0]   = up_q;
      end
      6'h1C: data_out[SHIFT_W-1:0] = sh_q;
      6'h20: if (!empty) data_out[SHIFT_W-1:0] = mem_q[rp_q[AW-1:0]];
      default: ;
    endcase
    for (int k = 0; k < NUM_CNT; k++)
      if (address == 6'(8 + 4 * k))
        data_out[CNT_W-1:0] = cnt_q[k];
  end

endmodule

// File: tb/tb_prism_cnt_shift_unit.sv
// Directed bench for prism_cnt_shift_unit: counters, up/compare counter,
// shifter in both directions, capture FIFO and asynchronous reset.
module tb_prism_cnt_shift_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  cnt_load, cnt_dec;
  logic        up_inc, up_clr, shift, ser_in;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n, data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic [1:0]  cnt_zero, cnt_wrap;
  logic        cmp_match, shift_done, ser_out, irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] d;

  prism_cnt_shift_unit dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cnt_load(cnt_load), .cnt_dec(cnt_dec),
    .up_inc(up_inc), .up_clr(up_clr),
    .shift(shift), .ser_in(ser_in),
    .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready),
    .cnt_zero(cnt_zero), .cnt_wrap(cnt_wrap),
    .cmp_match(cmp_match), .shift_done(shift_done),
    .ser_out(ser_out), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] v);
    address = a;
    data_in = v;
    data_write_n = 2'b10;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic peek(input logic [5:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] v);
    address = a;
    data_read_n = 2'b00;
    #1;
    v = data_out;
    tick();
    data_read_n = 2'b11;
  endtask

  task automatic shbit(input logic b);
    ser_in = b;
    shift = 1'b1;
    tick();
    shift = 1'b0;
  endtask

  task automatic push2(input logic [1:0] w);
    shbit(w[1]);
    shbit(w[0]);
  endtask

  logic [31:0] exp_cnt [6];
  logic [1:0]  exp_wrap [6];
  logic [7:0]  pat;
  logic [1:0]  fw [4];

  initial begin
    exp_cnt  = '{32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3};
    exp_wrap = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    rst = 1'b1; enable = 1'b0;
    cnt_load = '0; cnt_dec = '0;
    up_inc = 1'b0; up_clr = 1'b0;
    shift = 1'b0; ser_in = 1'b0;
    address = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    tick(); tick();
    rst = 1'b0;

    peek(6'h00, d); check("rst_ctrl", d, 32'h0);
    peek(6'h04, d); check("rst_status", d, 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_zero", 32'(cnt_zero), 32'h3);
    check("rst_wrap", 32'(cnt_wrap), 32'h0);
    check("rst_done", 32'(shift_done), 32'h0);
    enable = 1'b1;

    // countdown with auto-reload on counter 0
    wr(6'h08, 32'd3);
    wr(6'h00, 32'h10);
    cnt_load = 2'b01;
    tick();
    cnt_load = 2'b00;
    peek(6'h08, d); check("cnt_load", d, 32'd3);
    cnt_dec = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      peek(6'h08, d); check("cnt_seq", d, exp_cnt[i]);
      check("cnt_wrap", 32'(cnt_wrap), 32'(exp_wrap[i]));
      check("cnt_zero0", 32'(cnt_zero[0]), 32'h0);
    end
    cnt_dec = 2'b00;
    tick();
    check("wrap_end", 32'(cnt_wrap), 32'h0);
    peek(6'h0C, d); check("cnt1_hold0", d, 32'h0);
    check("cnt1_zero", 32'(cnt_zero[1]), 32'h1);
    cnt_load = 2'b01; cnt_dec = 2'b01;
    tick();
    cnt_load = 2'b00; cnt_dec = 2'b00;
    peek(6'h08, d); check("ld_dec_hold", d, 32'd3);
    enable = 1'b0; cnt_dec = 2'b01;
    tick();
    cnt_dec = 2'b00; enable = 1'b1;
    peek(6'h08, d); check("en_low_hold", d, 32'd3);

    // 8-bit word 0xA5 MSB-first into the FIFO
    wr(6'h00, 32'h0702);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      shbit(pat[i]);
      if (i == 1) check("a5_done7", 32'(shift_done), 32'h0);
    end
    check("a5_done8", 32'(shift_done), 32'h1);
    check("a5_serout", 32'(ser_out), 32'h1);
    peek(6'h04, d); check("a5_status", d, 32'h100);
    rd(6'h20, d); check("a5_pop", d, 32'hA5);
    peek(6'h04, d); check("a5_empty", d, 32'h1);
    rd(6'h20, d); check("empty_pop", d, 32'h0);

    // 2-bit words: fill, push+pop while full, then overflow
    wr(6'h00, 32'h0102);
    push2(2'd1); push2(2'd2); push2(2'd3); push2(2'd0);
    peek(6'h04, d); check("ff_full", d, 32'h402);
    shbit(1'b0);
    address = 6'h20; data_read_n = 2'b00;
    ser_in = 1'b1; shift = 1'b1;
    #1;
    check("ff_pp_head", data_out, 32'h1);
    tick();
    shift = 1'b0; data_read_n = 2'b11;
    peek(6'h04, d); check("ff_pp_noovf", d, 32'h402);
    check("ff_pp_irq", 32'(irq), 32'h0);
    push2(2'd3);
    peek(6'h04, d); check("ff_ovf", d, 32'h406);
    check("ff_ovf_irq", 32'(irq), 32'h1);
    fw = '{2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      rd(6'h20, d); check("ff_pop", d, 32'(fw[i]));
    end
    peek(6'h04, d); check("ff_drained", d, 32'h5);
    wr(6'h04, 32'h4);
    peek(6'h04, d); check("ff_w1c", d, 32'h1);
    check("ff_irq_clr", 32'(irq), 32'h0);
    wr(6'h00, 32'h0106);
    push2(2'd2);
    check("fie_irq", 32'(irq), 32'h1);
    rd(6'h20, d); check("fie_pop", d, 32'h2);
    check("fie_irq_off", 32'(irq), 32'h0);

    // up counter vs compare
    wr(6'h18, 32'd3);
    up_inc = 1'b1;
    tick(); tick();
    check("up_nomatch", 32'(cmp_match), 32'h0);
    tick();
    up_inc = 1'b0;
    check("up_match", 32'(cmp_match), 32'h1);
    peek(6'h18, d); check("up_cmpreg", d, 32'h0003_0003);
    up_inc = 1'b1; up_clr = 1'b1;
    tick();
    up_inc = 1'b0; up_clr = 1'b0;
    peek(6'h18, d); check("up_both_hold", d, 32'h0003_0003);
    peek(6'h04, d); check("up_event", d, 32'h9);
    check("up_evt_irq", 32'(irq), 32'h1);
    wr(6'h04, 32'h8);
    check("up_evt_clr", 32'(irq), 32'h0);
    up_clr = 1'b1;
    tick();
    up_clr = 1'b0;
    peek(6'h18, d); check("up_clr", d, 32'h0003_0000);
    check("up_clr_nm", 32'(cmp_match), 32'h0);

    // host SHDATA write beats a same-cycle shift
    wr(6'h00, 32'h0700);
    shbit(1'b1); shbit(1'b1); shbit(1'b1);
    address = 6'h1C; data_in = 32'h0F; data_write_n = 2'b10;
    ser_in = 1'b0; shift = 1'b1;
    tick();
    data_write_n = 2'b11; shift = 1'b0;
    peek(6'h1C, d); check("sh_wr_wins", d, 32'h0F);
    shbit(1'b1);
    peek(6'h1C, d); check("sh_next", d, 32'h1F);
    for (int i = 0; i < 6; i++) shbit(1'b0);
    check("sh_done7", 32'(shift_done), 32'h0);
    shbit(1'b0);
    check("sh_done8", 32'(shift_done), 32'h1);
    peek(6'h1C, d); check("sh_val", d, 32'h80);

    // LSB-first shifting
    wr(6'h00, 32'h0701);
    wr(6'h1C, 32'h0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) shbit(pat[i]);
    peek(6'h1C, d); check("lsb_word", d, 32'hA5);
    check("lsb_serout", 32'(ser_out), 32'h1);

    // reset mid-word
    wr(6'h00, 32'h0702);
    wr(6'h1C, 32'h0);
    shbit(1'b1); shbit(1'b1); shbit(1'b1);
    rst = 1'b1;
    #1;
    check("mr_done", 32'(shift_done), 32'h0);
    check("mr_irq", 32'(irq), 32'h0);
    check("mr_wrap", 32'(cnt_wrap), 32'h0);
    check("mr_serout", 32'(ser_out), 32'h0);
    check("mr_zero", 32'(cnt_zero), 32'h3);
    peek(6'h04, d); check("mr_status", d, 32'h1);
    peek(6'h00, d); check("mr_ctrl", d, 32'h0);
    peek(6'h08, d); check("mr_cnt0", d, 32'h0);
    peek(6'h1C, d); check("mr_shreg", d, 32'h0);
    tick();
    rst = 1'b0;
    wr(6'h00, 32'h0702);
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) shbit(pat[i]);
    peek(6'h04, d); check("mr_status2", d, 32'h100);
    rd(6'h20, d); check("mr_pop", d, 32'h3C);
    peek(6'h04, d); check("mr_empty", d, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prism_cnt_shift_unit.md
Name: prism_cnt_shift_unit

Overview:
- Parametrised counter/shifter datapath that sits beside the PRISM FSM inside a TinyQV peripheral.
- Generalises the single 24-bit countdown, 5-bit up-counter and 8/24-bit shifter to NUM_CNT reloadable countdown counters, an UP_W-bit compare counter and a SHIFT_W-bit shifter with programmable word length.
- Completed shift words are captured into a FIFO that the host pops over the peripheral register bus; an interrupt covers FIFO data, overflow and the clr+inc event.

Parameters:
- NUM_CNT, 2: number of countdown counters (1..4).
- CNT_W, 24: countdown counter width (1..32).
- UP_W, 5: up-counter and compare width (1..16).
- SHIFT_W, 8: shift register width (1..32).
- FIFO_DEPTH, 4: capture FIFO depth (power of two, 2..16).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  FSM executing; all FSM control inputs are ignored while low
- cnt_load  in  NUM_CNT  per-counter load strobe
- cnt_dec  in  NUM_CNT  per-counter decrement strobe
- up_inc  in  1  up-counter increment
- up_clr  in  1  up-counter clear
- shift  in  1  shift strobe
- ser_in  in  1  serial data in
- address  in  6  register address
- data_in  in  32  write data
- data_write_n  in  2  11 = none, 10 = 32-bit; only 10 is accepted
- data_read_n  in  2  11 = none, any other value = read
- data_out  out  32  read data (combinational)
- data_ready  out  1  tied 1
- cnt_zero  out  NUM_CNT  counter k == 0 (combinational)
- cnt_wrap  out  NUM_CNT  registered 1-cycle pulse on auto-reload
- cmp_match  out  1  up-counter == CMP (combinational)
- shift_done  out  1  registered 1-cycle pulse when a word completes
- ser_out  out  1  current outgoing bit
- irq  out  1  level interrupt

Behaviour:
- Reset: all registers, counters, FIFO pointers, sticky flags, cnt_wrap and shift_done go to 0. FIFO is empty. data_out reads 0 at address 0x00. Reset mid-word discards the partial word.
- Register map:
  - 0x00 CTRL (RW): [0] dir (1 = LSB-first); [1] fifo_en; [2] fifo_irq_en; [7:4] autoreload mask; [12:8] len_m1.
  - 0x04 STATUS: [0] empty; [1] full; [2] overflow (W1C); [3] event (W1C); [8+:] FIFO level.
  - 0x08+4k PRELOAD k: write sets the preload; read returns the live count.
  - 0x18 CMP: read returns {cmp[31:16], upcount[15:0]} zero-extended.
  - 0x1C SHDATA: RW shift register.
  - 0x20 FIFO: a read returns the head and pops; a read when empty returns 0 and does not pop.
- len_m1 values >= SHIFT_W are treated as SHIFT_W-1; effective word length L = len_m1+1.
- Countdown counter k, each cycle with enable=1:
  - load & !dec: count <= preload.
  - dec & !load & count != 0: if autoreload[k] and count == 1, count <= preload and cnt_wrap[k] pulses next cycle; otherwise count <= count-1.
  - dec at count 0: hold (no wrap below zero).
  - load & dec together: hold.
- Up counter:
  - inc only: +1, wrapping mod 2^UP_W.
  - clr only: 0.
  - inc & clr together: hold, and set sticky event.
- Shifter, on shift & enable:
  - dir=0: shreg <= {shreg[SHIFT_W-2:0], ser_in}.
  - dir=1: ser_in enters bit L-1 and bits [L-1:1] shift down.
  - ser_out = dir ? shreg[0] : shreg[L-1].
  - bitcnt increments. At bitcnt == L-1, bitcnt <= 0, shift_done pulses, and if fifo_en the new word, masked to L bits, is pushed.
- Host write to SHDATA: loads shreg and zeroes bitcnt. It wins over a same-cycle shift.
- FIFO:
  - Push when full sets overflow and drops the word.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: the read returns 0 and the word is stored.
- irq = overflow | event | (fifo_irq_en & !empty).
- Host register writes are honoured regardless of enable.

Test Plan:
- PRELOAD0=3, autoreload bit0=1, hold cnt_dec with enable=1 -> count sequence 3,2,1,3,2,1; cnt_wrap[0] pulses one cycle after each 1->3 transition; cnt_zero[0] never asserts.
- len_m1=7, dir=0, fifo_en=1, shift in 0xA5 MSB-first -> shift_done pulse after the 8th shift; FIFO read returns 0xA5; STATUS.empty=1 afterwards.
- fifo_en=1, push 5 words with FIFO_DEPTH=4 -> STATUS.full=1, overflow=1, irq=1; pops return the first 4 words in order; writing 0x4 to STATUS clears overflow.
- CMP=3, pulse up_inc 3 times -> cmp_match=1; assert up_inc and up_clr together -> count holds at 3, event=1, irq=1.
- Write SHDATA=0x0F in the same cycle as a shift -> shreg=0x0F and bitcnt=0; next shift with ser_in=1 -> 0x1F.
- Assert rst mid-word after 3 of 8 shifts -> all outputs 0, FIFO empty, counts 0; the next full 8-bit word pushes correctly.
